a2bus_packet_fifo: RTL and testbench

Elastic packet buffer between the Apple II bus capture stage and the CAM serializer. It absorbs bursts of 32-bit capture packets, meters them out one at a time under the serializer's busy handshake, and counts packets dropped on overflow. After any run of drops it injects a drop-marker packet in stream order, so the ESP32 host can detect gaps.

---
 rtl/a2bus_stream_pkg.sv | 36 +++
 rtl/a2bus_pkt_ram.sv | 27 ++
 rtl/a2bus_packet_fifo.sv | 127 ++++++++++++
 tb/tb_a2bus_packet_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/a2bus_stream_pkg.sv
// Shared definitions for the Apple II bus capture packet stream.
// Covers the packet layout, the flag bit positions and the drop-marker builder.
package a2bus_stream_pkg;

    localparam int unsigned PKT_W     = 32;
    localparam int unsigned ADDR_LSB  = 16;
    localparam int unsigned DATA_LSB  = 8;
    localparam int unsigned FLAGS_LSB = 0;

    localparam int unsigned FLAG_RW_N    = 7;
    localparam int unsigned FLAG_M2SEL_N = 6;
    localparam int unsigned FLAG_M2B0    = 5;
    localparam int unsigned FLAG_SW_GS   = 4;
    localparam int unsigned FLAG_MARKER  = 1;
    localparam int unsigned FLAG_RESET   = 0;

    localparam logic [15:0] MARKER_ADDR_DEFAULT = 16'hC0FE;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  flags;
    } a2bus_pkt_t;

    // The drop count rides in the data byte; only the marker flag is set.
    function automatic a2bus_pkt_t build_marker(input logic [15:0] addr,
                                                input logic [7:0]  drops);
        a2bus_pkt_t pkt;
        pkt.addr               = addr;
        pkt.data               = drops;
        pkt.flags              = 8'h00;
        pkt.flags[FLAG_MARKER] = 1'b1;
        return pkt;
    endfunction

endpackage

// File: rtl/a2bus_pkt_ram.sv
// Packet storage: synchronous write, asynchronous read, so it maps to distributed RAM.
module a2bus_pkt_ram
    import a2bus_stream_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  a2bus_pkt_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output a2bus_pkt_t        rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    a2bus_pkt_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/a2bus_packet_fifo.sv
// Elastic packet buffer between bus capture and the CAM serializer.
// Drops on overflow, then injects a drop-marker packet in stream order.
module a2bus_packet_fifo
    import a2bus_stream_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter logic [15:0] MARKER_ADDR = MARKER_ADDR_DEFAULT
) (
    input  logic                  clk_logic,
    input  logic                  system_reset_n,
    input  logic                  wr_i,
    input  logic [31:0]           data_i,
    input  logic                  flush_i,
    output logic                  full_o,
    input  logic                  rd_busy_i,
    output logic                  wr_o,
    output logic [31:0]           data_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o,
    output logic [15:0]           drop_count_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] level_d;
    logic [7:0]       pend_q, pend_d;
    logic [15:0]      drop_cnt_d;

    logic       empty_c;
    logic       full_c;
    logic       drop_c;
    logic       push_c;
    logic       pop_c;
    a2bus_pkt_t push_pkt_c;
    a2bus_pkt_t head_pkt_c;

    a2bus_pkt_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk_logic),
        .we      (push_c),
        .waddr   (wptr_q[DEPTH_LOG2-1:0]),
        .wdata   (push_pkt_c),
        .raddr   (rptr_q[DEPTH_LOG2-1:0]),
        .rdata_c (head_pkt_c)
    );

    assign empty_c = (wptr_q == rptr_q);
    assign full_c  = (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]) &&
                     (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]);

    // Next-state: drop accounting, push/marker selection, pop, flush override.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        pend_d     = pend_q;
        drop_cnt_d = drop_count_o;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        push_pkt_c = a2bus_pkt_t'(data_i);

        // Writes are refused while drops are pending so the marker lands first.
        drop_c = wr_i && (full_c || (pend_q != 8'd0));
        if (drop_c && (drop_count_o != 16'hFFFF)) begin
            drop_cnt_d = drop_count_o + 16'd1;
        end

        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            pend_d = '0;
        end else begin
            if (wr_i && !drop_c) begin
                push_c = 1'b1;
            end else if (drop_c) begin
                if (pend_q != 8'hFF) begin
                    pend_d = pend_q + 8'd1;
                end
            end else if ((pend_q != 8'd0) && !full_c) begin
                push_c     = 1'b1;
                push_pkt_c = build_marker(MARKER_ADDR, pend_q);
                pend_d     = 8'd0;
            end

            pop_c = !empty_c && !rd_busy_i && !wr_o;

            if (push_c) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
        end

        level_d = wptr_d - rptr_d;
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            pend_q       <= '0;
            drop_count_o <= '0;
            level_o      <= '0;
            full_o       <= 1'b0;
            overflow_o   <= 1'b0;
            wr_o         <= 1'b0;
            data_o       <= 32'h0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            pend_q       <= pend_d;
            drop_count_o <= drop_cnt_d;
            level_o      <= level_d;
            full_o       <= (level_d == PTR_W'(DEPTH));
            overflow_o   <= (pend_d != 8'd0);
            wr_o         <= pop_c;
            if (pop_c) begin
                data_o <= head_pkt_c;
            end
        end
    end

endmodule

// File: tb/tb_a2bus_packet_fifo.sv
// Scoreboard bench for a2bus_packet_fifo: expected packets queued on write,
// compared against every wr_o strobe seen at the serializer side.
module tb_a2bus_packet_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_i = 1'b0;
    logic [31:0] data_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        hold_busy = 1'b0;
    logic        busy_pulse = 1'b0;
    logic        rd_busy_i;
    logic        full_o;
    logic        wr_o;
    logic [31:0] data_o;
    logic [4:0]  level_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;

    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_issued = 0;
    logic        prev_wr_o = 1'b0;

    a2bus_packet_fifo dut (
        .clk_logic      (clk),
        .system_reset_n (rst_n),
        .wr_i           (wr_i),
        .data_i         (data_i),
        .flush_i        (flush_i),
        .full_o         (full_o),
        .rd_busy_i      (rd_busy_i),
        .wr_o           (wr_o),
        .data_o         (data_o),
        .level_o        (level_o),
        .overflow_o     (overflow_o),
        .drop_count_o   (drop_count_o)
    );

    always #5 clk = ~clk;

    // Serializer model: busy for the cycle following each strobe.
    always @(posedge clk) busy_pulse <= wr_o;
    assign rd_busy_i = hold_busy | busy_pulse;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_o) begin
            n_issued++;
            chk("wr_o_one_cycle", 32'(prev_wr_o), 32'd0);
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                chk("issue_data", data_o, sb.pop_front());
            end
        end
        prev_wr_o = wr_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pkt(input logic [31:0] d, input bit acc);
        wr_i   = 1'b1;
        data_i = d;
        if (acc) sb.push_back(d);
        tick();
        wr_i = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((sb.size() != 0 || wr_o) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) tick();
    endtask

    function automatic logic [31:0] mk_pkt(input int i);
        return {16'hC000 + 16'(i), 8'(i * 3 + 1), 8'h80};
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wr_o"}, 32'(wr_o), 32'd0);
        chk({tag, "_data_o"}, data_o, 32'h0);
        chk({tag, "_full"}, 32'(full_o), 32'd0);
        chk({tag, "_level"}, 32'(level_o), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow_o), 32'd0);
        chk({tag, "_drops"}, 32'(drop_count_o), 32'd0);
    endtask

    initial begin
        int base;
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single packet latency
        base = n_issued;
        write_pkt(32'hC030A580, 1'b1);
        chk("t1_level_after_wr", 32'(level_o), 32'd1);
        chk("t1_wr_o_early", 32'(wr_o), 32'd0);
        tick();
        chk("t1_wr_o_lat2", 32'(wr_o), 32'd1);
        chk("t1_data_o", data_o, 32'hC030A580);
        tick();
        chk("t1_wr_o_fall", 32'(wr_o), 32'd0);
        repeat (4) tick();
        chk("t1_level_zero", 32'(level_o), 32'd0);
        chk("t1_issue_count", 32'(n_issued - base), 32'd1);

        // Fill to full, then overflow by three
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_pkt(mk_pkt(i), 1'b1);
        chk("t2_full", 32'(full_o), 32'd1);
        chk("t2_level16", 32'(level_o), 32'd16);
        for (int i = 0; i < 3; i++) write_pkt(32'hDEAD0000 + 32'(i), 1'b0);
        chk("t2_drops3", 32'(drop_count_o), 32'd3);
        chk("t2_overflow", 32'(overflow_o), 32'd1);
        chk("t2_level_held", 32'(level_o), 32'd16);
        sb.push_back(32'hC0FE0302);
        hold_busy = 1'b0;
        wait_drain(200);
        chk("t3_overflow_clr", 32'(overflow_o), 32'd0);
        chk("t3_level_zero", 32'(level_o), 32'd0);

        // Drop while pending with space free
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_pkt(mk_pkt(i + 32), 1'b1);
        write_pkt(32'hBAD00001, 1'b0);
        hold_busy = 1'b0;
        tick();
        chk("t4_level15", 32'(level_o), 32'd15);
        write_pkt(32'hBAD00002, 1'b0);
        chk("t4_drops5", 32'(drop_count_o), 32'd5);
        sb.push_back(32'hC0FE0202);
        wait_drain(200);
        chk("t4_overflow_clr", 32'(overflow_o), 32'd0);

        // Simultaneous push and pop at level 5
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_pkt(mk_pkt(i + 64), 1'b1);
        chk("t5_level5", 32'(level_o), 32'd5);
        hold_busy = 1'b0;
        write_pkt(mk_pkt(69), 1'b1);
        hold_busy = 1'b1;
        chk("t5_level_still5", 32'(level_o), 32'd5);
        chk("t5_popped", 32'(wr_o), 32'd1);
        tick();
        hold_busy = 1'b0;
        wait_drain(200);

        // Flush discards contents but keeps drop total
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) write_pkt(mk_pkt(i + 80), 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        sb.delete();
        chk("fl_level0", 32'(level_o), 32'd0);
        chk("fl_drops_kept", 32'(drop_count_o), 32'd5);
        base = n_issued;
        hold_busy = 1'b0;
        repeat (6) tick();
        chk("fl_no_issue", 32'(n_issued - base), 32'd0);

        // Reset mid-stream at level 7
        hold_busy = 1'b1;
        for (int i = 0; i < 7; i++) write_pkt(mk_pkt(i + 96), 1'b1);
        chk("t6_level7", 32'(level_o), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("t6");
        sb.delete();
        tick();
        rst_n = 1'b1;
        hold_busy = 1'b0;
        tick();
        write_pkt(32'h12345678, 1'b1);
        wait_drain(50);
        chk("t6_level_end", 32'(level_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
